// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute sequencer for the 8-bit CPU.
// Owns the program counter, the instruction register and the zero flag.
// Optional feature macro SINGLE_STEP_EN adds a step input and a STEP_WAIT
// state that parks the sequencer after every EXECUTE until step is seen.
module cpu_sequencer #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
`ifdef SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic [3:0]        opcode,
    output logic [3:0]        rd,
    output logic [7:0]        imm,
    input  logic              ctrl_write_enable,
    input  logic              ctrl_jmp_enable,
    input  logic [7:0]        alu_result,
    output logic              zero_flag,
    output logic              rf_we,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

`ifdef SINGLE_STEP_EN
    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXECUTE, HALT, STEP_WAIT
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXECUTE, HALT
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic                zf_q, zf_d;
    logic                we_q, we_d;
    logic                jmp_q, jmp_d;
    logic                rf_we_q, rf_we_d;
    logic                halted_q, halted_d;

    // State and datapath registers; every register returns to its reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            ir_q     <= 16'h0000;
            zf_q     <= 1'b0;
            we_q     <= 1'b0;
            jmp_q    <= 1'b0;
            rf_we_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            zf_q     <= zf_d;
            we_q     <= we_d;
            jmp_q    <= jmp_d;
            rf_we_q  <= rf_we_d;
            halted_q <= halted_d;
        end
    end

    // Next-state logic: sequencing plus PC, IR, flag and latched control updates.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        zf_d    = zf_q;
        we_d    = we_q;
        jmp_d   = jmp_q;
        rf_we_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                // Acks are only meaningful here; elsewhere they are ignored.
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (ir_q[15:12] == 4'hF) begin
                    // Halt still advances the PC so a restart resumes past it.
                    pc_d    = pc_q + 1'b1;
                    state_d = HALT;
                end else begin
                    we_d    = ctrl_write_enable;
                    jmp_d   = ctrl_jmp_enable;
                    rf_we_d = ctrl_write_enable;
                    state_d = EXECUTE;
                end
            end
            EXECUTE: begin
                if (we_q) zf_d = (alu_result == 8'h00);
                pc_d = jmp_q ? ir_q[ADDR_W-1:0] : pc_q + 1'b1;
`ifdef SINGLE_STEP_EN
                state_d = STEP_WAIT;
`else
                state_d = FETCH;
`endif
            end
            HALT: begin
                if (run) state_d = FETCH;
            end
`ifdef SINGLE_STEP_EN
            STEP_WAIT: begin
                if (step) state_d = FETCH;
            end
`endif
            default: state_d = IDLE;
        endcase
        halted_d = (state_d == HALT);
    end

    assign imem_req  = (state_q == FETCH);
    assign imem_addr = pc_q;
    assign opcode    = ir_q[15:12];
    assign rd        = ir_q[11:8];
    assign imm       = ir_q[7:0];
    assign zero_flag = zf_q;
    assign rf_we     = rf_we_q;
    assign pc        = pc_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed testbench for cpu_sequencer: an 8-bit-PC instance and a 4-bit-PC
// instance run in lockstep from the same instruction stream.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        ack = 1'b0;
    logic [15:0] rdata = 16'h0000;
    logic [7:0]  alu = 8'h00;
    logic        step = 1'b1;
    logic        ctrl_we, ctrl_jmp;

    logic        req8, zf8, rfwe8, halt8;
    logic [7:0]  addr8, pc8, imm8;
    logic [3:0]  opc8, rd8;
    logic        req4, zf4, rfwe4, halt4;
    logic [3:0]  addr4, pc4, opc4, rd4;
    logic [7:0]  imm4;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int c0     = 0;

`ifdef SINGLE_STEP_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    always #5 clk = ~clk;

    // Control-unit stand-in: opcodes 1/2 write, D jumps always, E jumps if zero.
    assign ctrl_we  = (opc8 == 4'h1) || (opc8 == 4'h2);
    assign ctrl_jmp = (opc8 == 4'hD) || ((opc8 == 4'hE) && zf8);

    cpu_sequencer #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .run(run),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .imem_req(req8), .imem_addr(addr8), .imem_ack(ack), .imem_rdata(rdata),
        .opcode(opc8), .rd(rd8), .imm(imm8),
        .ctrl_write_enable(ctrl_we), .ctrl_jmp_enable(ctrl_jmp), .alu_result(alu),
        .zero_flag(zf8), .rf_we(rfwe8), .pc(pc8), .halted(halt8)
    );

    cpu_sequencer #(.ADDR_W(4)) dut4 (
        .clk(clk), .rst(rst), .run(run),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .imem_req(req4), .imem_addr(addr4), .imem_ack(ack), .imem_rdata(rdata),
        .opcode(opc4), .rd(rd4), .imm(imm4),
        .ctrl_write_enable(ctrl_we), .ctrl_jmp_enable(ctrl_jmp), .alu_result(alu),
        .zero_flag(zf4), .rf_we(rfwe4), .pc(pc4), .halted(halt4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Leave EXECUTE; in single-step builds also pass through STEP_WAIT (step=1).
    task automatic exec_end();
        tick();
`ifdef SINGLE_STEP_EN
        tick();
`endif
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_req", req8, 1'b0);
        chk("rst_pc", pc8, 8'h00);
        chk("rst_halted", halt8, 1'b0);
        chk("rst_rfwe", rfwe8, 1'b0);
        chk("rst_zf", zf8, 1'b0);
        chk("rst_opcode", opc8, 4'h0);
        rst = 1'b0;
        tick();
        chk("idle_no_req", req8, 1'b0);

        // First instruction: 1305, ack in first fetch cycle, write of 05
        run = 1'b1; tick(); run = 1'b0;
        c0 = cyc;
        chk("fetch0_req", req8, 1'b1);
        chk("fetch0_addr", addr8, 8'h00);
        ack = 1'b1; rdata = 16'h1305; alu = 8'h05;
        tick(); ack = 1'b0;
        chk("dec_req_low", req8, 1'b0);
        chk("dec_opcode", opc8, 4'h1);
        chk("dec_rd", rd8, 4'h3);
        chk("dec_imm", imm8, 8'h05);
        chk("dec_rfwe", rfwe8, 1'b0);
        tick();
        chk("exe_rfwe", rfwe8, 1'b1);
        chk("exe_pc", pc8, 8'h00);
        exec_end();
        chk("after_rfwe", rfwe8, 1'b0);
        chk("after_pc", pc8, 8'h01);
        chk("after_zf", zf8, 1'b0);
        chk("fetch1_req", req8, 1'b1);
        chk("fetch1_addr", addr8, 8'h01);
        chk("latency", cyc - c0, LAT);

        // Write of 00 sets Z, then E020 jumps on zero
        ack = 1'b1; rdata = 16'h1200; alu = 8'h00;
        tick(); ack = 1'b0; tick(); exec_end();
        chk("z_set", zf8, 1'b1);
        chk("z_pc", pc8, 8'h02);
        ack = 1'b1; rdata = 16'hE020;
        tick(); ack = 1'b0; tick();
        chk("jz_rfwe", rfwe8, 1'b0);
        exec_end();
        chk("jz_pc", pc8, 8'h20);
        chk("jz_pc4", pc4, 4'h0);
        chk("jz_zf_kept", zf8, 1'b1);

        // Ack delayed 4 cycles; spurious ack in DECODE
        rdata = 16'hF0F0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wait_req", req8, 1'b1);
            chk("wait_addr", addr8, 8'h20);
            chk("wait_ir", opc8, 4'hE);
        end
        ack = 1'b1; rdata = 16'h2107;
        tick();
        chk("late_opcode", opc8, 4'h2);
        chk("late_imm", imm8, 8'h07);
        rdata = 16'hFFFF; alu = 8'h07;
        tick();
        chk("spur_opcode", opc8, 4'h2);
        chk("spur_rfwe", rfwe8, 1'b1);
        ack = 1'b0;
        exec_end();
        chk("late_pc", pc8, 8'h21);
        chk("late_zf", zf8, 1'b0);

        // Jump to 7, then halt there
        ack = 1'b1; rdata = 16'hD007;
        tick(); ack = 1'b0; tick(); exec_end();
        chk("j7_pc", pc8, 8'h07);
        chk("j7_pc4", pc4, 4'h7);
        ack = 1'b1; rdata = 16'hF000;
        tick(); ack = 1'b0;
        chk("hlt_dec_halted", halt8, 1'b0);
        tick();
        chk("hlt_halted", halt8, 1'b1);
        chk("hlt_halted4", halt4, 1'b1);
        chk("hlt_pc", pc8, 8'h08);
        chk("hlt_req", req8, 1'b0);
        tick(); tick();
        chk("hlt_hold_req", req8, 1'b0);
        chk("hlt_hold_halted", halt8, 1'b1);
        chk("hlt_hold_pc", pc8, 8'h08);
        run = 1'b1; tick(); run = 1'b0;
        chk("resume_halted", halt8, 1'b0);
        chk("resume_req", req8, 1'b1);
        chk("resume_addr", addr8, 8'h08);

        // PC wrap at FF and 4-bit jump truncation
        ack = 1'b1; rdata = 16'hD0FF;
        tick(); ack = 1'b0; tick(); exec_end();
        chk("jff_pc", pc8, 8'hFF);
        chk("jff_pc4", pc4, 4'hF);
        ack = 1'b1; rdata = 16'h1000; alu = 8'h00;
        tick(); ack = 1'b0; tick();
        chk("wrap_rfwe", rfwe8, 1'b1);
        exec_end();
        chk("wrap_pc", pc8, 8'h00);
        chk("wrap_pc4", pc4, 4'h0);
        chk("wrap_zf", zf8, 1'b1);
        ack = 1'b1; rdata = 16'hD03A;
        tick(); ack = 1'b0; tick(); exec_end();
        chk("j3a_pc", pc8, 8'h3A);
        chk("j3a_pc4", pc4, 4'hA);

        // Reset while a fetch is outstanding
        tick();
        chk("pre_rst_req", req8, 1'b1);
        rst = 1'b1; tick();
        chk("midrst_req", req8, 1'b0);
        chk("midrst_req4", req4, 1'b0);
        chk("midrst_pc", pc8, 8'h00);
        chk("midrst_opcode", opc8, 4'h0);
        chk("midrst_zf", zf8, 1'b0);
        chk("midrst_halted", halt8, 1'b0);
        rst = 1'b0; tick();
        chk("midrst_idle", req8, 1'b0);

`ifdef SINGLE_STEP_EN
        // Single step: no fetch after EXECUTE until step=1
        step = 1'b0;
        run = 1'b1; tick(); run = 1'b0;
        ack = 1'b1; rdata = 16'h3000;
        tick(); ack = 1'b0; tick(); tick();
        for (int i = 0; i < 3; i++) begin
            chk("step_wait_req", req8, 1'b0);
            tick();
        end
        chk("step_wait_pc", pc8, 8'h01);
        step = 1'b1; tick();
        chk("step_go_req", req8, 1'b1);
        chk("step_go_addr", addr8, 8'h01);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
